// File: rtl/multi_core_pkg.sv
// Shared constants for the multi-core dispatch/collect block.
// Mode encodings, err bit indices and default sizing.
package multi_core_pkg;

    localparam logic MODE_RR       = 1'b0;
    localparam logic MODE_DIRECTED = 1'b1;

    localparam int ERR_BADCORE   = 0;
    localparam int ERR_UNDERFLOW = 1;

    localparam int DEF_NUM_CORES       = 4;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/multi_core_dispatch_rr_arbiter.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; one-hot grant, grant index, found out.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/multi_core_dispatch.sv
// Dispatches one instruction stream across NUM_CORES cores with per-core
// credits, and merges the per-core result streams into one tagged stream.
// Ports: clock/reset_n; mode; instr_* in; core_instr_* out; core_result_*
// in; result_* out; core_busy (credit != 0); err pulses.
module multi_core_dispatch
    import multi_core_pkg::*;
#(
    parameter  int NUM_CORES       = DEF_NUM_CORES,
    parameter  int DATA_W          = DEF_DATA_W,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int CORE_ID_W       = $clog2(NUM_CORES),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        mode,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [DATA_W-1:0]           instr_data,
    input  logic [CORE_ID_W-1:0]        instr_core,
    output logic [NUM_CORES-1:0]        core_instr_valid,
    input  logic [NUM_CORES-1:0]        core_instr_ready,
    output logic [NUM_CORES*DATA_W-1:0] core_instr_data,
    input  logic [NUM_CORES-1:0]        core_result_valid,
    output logic [NUM_CORES-1:0]        core_result_ready,
    input  logic [NUM_CORES*DATA_W-1:0] core_result_data,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [DATA_W-1:0]           result_data,
    output logic [CORE_ID_W-1:0]        result_core,
    output logic [NUM_CORES-1:0]        core_busy,
    output logic [1:0]                  err
);

    // Core ids span a power of two; ids past NUM_CORES are invalid.
    localparam int ID_SPAN = 1 << CORE_ID_W;
    localparam logic [ID_SPAN-1:0] ID_OK =
        {ID_SPAN{1'b1}} >> (ID_SPAN - NUM_CORES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CORE_ID_W-1:0] LAST_ID = CORE_ID_W'(NUM_CORES - 1);

    logic [NUM_CORES-1:0] slot_v;
    logic [DATA_W-1:0]    slot_d [NUM_CORES];
    logic [CNT_W-1:0]     credit [NUM_CORES];
    logic [CORE_ID_W-1:0] disp_ptr;
    logic [CORE_ID_W-1:0] col_ptr;

    logic [NUM_CORES-1:0] elig;
    logic [ID_SPAN-1:0]   elig_ext;
    logic [ID_SPAN-1:0]   dir_oh;
    logic                 bad_id;
    logic                 accept;
    logic [NUM_CORES-1:0] disp_hit;

    logic [NUM_CORES-1:0] rr_grant;
    logic [CORE_ID_W-1:0] rr_idx;
    logic                 rr_found;

    logic [NUM_CORES-1:0] col_grant;
    logic [CORE_ID_W-1:0] col_idx;
    logic                 col_found;
    logic                 out_free;
    logic                 col_hs;
    logic [NUM_CORES-1:0] res_hs;
    logic [NUM_CORES-1:0] uflow;

    // A slot can take a new word if empty or draining this cycle.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            elig[c] = (!slot_v[c] || core_instr_ready[c])
                   && (credit[c] < CNT_MAX);
        end
    end

    assign elig_ext = ID_SPAN'(elig);
    assign dir_oh   = ID_SPAN'(1) << instr_core;
    assign bad_id   = !ID_OK[instr_core];

    rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .req   (elig),
        .ptr   (disp_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        instr_ready = 1'b0;
        disp_hit    = '0;
        unique case (mode)
            MODE_RR: begin
                instr_ready = rr_found;
                disp_hit    = rr_grant;
            end
            MODE_DIRECTED: begin
                // Bad ids are swallowed so the stream never wedges.
                instr_ready = bad_id || elig_ext[instr_core];
                disp_hit    = bad_id ? '0 : dir_oh[NUM_CORES-1:0];
            end
        endcase
        accept = instr_valid && instr_ready;
        if (!accept) begin
            disp_hit = '0;
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_col_arb (
        .req   (core_result_valid),
        .ptr   (col_ptr),
        .grant (col_grant),
        .idx   (col_idx),
        .found (col_found)
    );

    assign out_free          = !result_valid || result_ready;
    assign col_hs            = out_free && col_found;
    assign core_result_ready = out_free ? col_grant : '0;
    assign res_hs            = core_result_valid & core_result_ready;

    always_comb begin
        core_instr_data = '0;
        uflow           = '0;
        core_busy       = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            core_instr_data[c*DATA_W +: DATA_W] = slot_d[c];
            uflow[c]     = res_hs[c] && (credit[c] == '0);
            core_busy[c] = (credit[c] != '0);
        end
    end

    assign core_instr_valid = slot_v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_v <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                slot_d[c] <= '0;
                credit[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (disp_hit[c]) begin
                    slot_v[c] <= 1'b1;
                    slot_d[c] <= instr_data;
                end else if (core_instr_ready[c]) begin
                    slot_v[c] <= 1'b0;
                end
                // Underflowing returns leave the counter pinned at 0.
                if (disp_hit[c] && !res_hs[c]) begin
                    credit[c] <= credit[c] + CNT_W'(1);
                end else if (res_hs[c] && !disp_hit[c]
                             && credit[c] != '0) begin
                    credit[c] <= credit[c] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_ptr     <= '0;
            col_ptr      <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_core  <= '0;
            err          <= '0;
        end else begin
            if (accept && mode == MODE_RR) begin
                disp_ptr <= (rr_idx == LAST_ID)
                          ? '0 : rr_idx + CORE_ID_W'(1);
            end
            if (col_hs) begin
                result_valid <= 1'b1;
                result_data  <= core_result_data[int'(col_idx)*DATA_W +: DATA_W];
                result_core  <= col_idx;
                col_ptr      <= (col_idx == LAST_ID)
                              ? '0 : col_idx + CORE_ID_W'(1);
            end else if (out_free) begin
                result_valid <= 1'b0;
            end
            err[ERR_BADCORE]   <= accept && (mode == MODE_DIRECTED) && bad_id;
            err[ERR_UNDERFLOW] <= |uflow;
        end
    end

endmodule
